// File: rtl/layer5_result_ctrl_pkg.sv
// Shared types and constants for the layer-5 result buffer sequencer.
package layer5_result_ctrl_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_e;

    localparam int unsigned ADDR_W = 16;

    // Counter width for a side length w; a width-1 buffer still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/layer5_raster_cnt.sv
// Two-dimensional raster counter: inner index runs fastest, both wrap to zero after (WIDTH-1, WIDTH-1).
module layer5_raster_cnt
    import layer5_result_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW   = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] inner,
    output logic [CW-1:0] outer,
    output logic          last
);

    localparam logic [CW-1:0] MAX = CW'(WIDTH - 1);

    logic inner_last;

    assign inner_last = (inner == MAX);
    assign last       = inner_last && (outer == MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inner <= '0;
            outer <= '0;
        end else if (clr) begin
            inner <= '0;
            outer <= '0;
        end else if (en) begin
            if (inner_last) begin
                inner <= '0;
                outer <= (outer == MAX) ? '0 : outer + 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer5_result_ctrl.sv
// Layer-5 result buffer sequencer: fills one frame in raster order, then drains it to the next stage.
module layer5_result_ctrl
    import layer5_result_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter bit          COL_MAJOR_READ = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              save_enable,
    output logic [ADDR_W-1:0] save_row_addr,
    output logic [ADDR_W-1:0] save_col_addr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              layer5_result_read_signal,
    output logic [ADDR_W-1:0] read_row_addr,
    output logic [ADDR_W-1:0] read_col_addr,
    output logic              frame_done
);

    localparam int unsigned CW = cnt_width(WIDTH);

    ctrl_state_e   state;
    ctrl_state_e   state_nxt;
    logic [CW-1:0] wr_col;
    logic [CW-1:0] wr_row;
    logic          wr_last;
    logic [CW-1:0] rd_inner;
    logic [CW-1:0] rd_outer;
    logic          rd_last;
    logic          rd_fire;

    assign save_enable               = in_valid & in_ready;
    assign rd_fire                   = out_valid & out_ready;
    assign layer5_result_read_signal = out_valid;

    layer5_raster_cnt #(.WIDTH(WIDTH)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (save_enable & ~flush),
        .clr   (flush),
        .inner (wr_col),
        .outer (wr_row),
        .last  (wr_last)
    );

    layer5_raster_cnt #(.WIDTH(WIDTH)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (rd_fire & ~flush),
        .clr   (flush),
        .inner (rd_inner),
        .outer (rd_outer),
        .last  (rd_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= rd_fire & rd_last & ~flush;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wr_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && rd_last) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
        // Abort wins over any handshake, including the final one of either phase.
        if (flush) state_nxt = FILL;
    end

    assign save_row_addr = ADDR_W'(wr_row);
    assign save_col_addr = ADDR_W'(wr_col);

    always_comb begin
        if (COL_MAJOR_READ) begin
            read_row_addr = ADDR_W'(rd_inner);
            read_col_addr = ADDR_W'(rd_outer);
        end else begin
            read_row_addr = ADDR_W'(rd_outer);
            read_col_addr = ADDR_W'(rd_inner);
        end
    end

endmodule

// File: tb/tb_layer5_result_ctrl.sv
// Scoreboard bench for layer5_result_ctrl: row-major, column-major and WIDTH=1 instances.
module tb_layer5_result_ctrl;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, save_enable, out_valid, read_signal, frame_done;
    logic [15:0] save_row_addr, save_col_addr, read_row_addr, read_col_addr;

    logic        cm_in_ready, cm_save_enable, cm_out_valid, cm_read_signal, cm_frame_done;
    logic [15:0] cm_save_row_addr, cm_save_col_addr, cm_read_row_addr, cm_read_col_addr;

    logic        w1_flush = 1'b0;
    logic        w1_in_valid = 1'b0;
    logic        w1_out_ready = 1'b0;
    logic        w1_in_ready, w1_save_enable, w1_out_valid, w1_read_signal, w1_frame_done;
    logic [15:0] w1_save_row_addr, w1_save_col_addr, w1_read_row_addr, w1_read_col_addr;

    int          checks = 0;
    int          passes = 0;
    int unsigned edge_cnt = 0;
    int unsigned fill_start_edge = 0;
    int          wq[$];
    int          rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    layer5_result_ctrl #(.WIDTH(W), .COL_MAJOR_READ(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .save_enable(save_enable), .save_row_addr(save_row_addr), .save_col_addr(save_col_addr),
        .out_ready(out_ready), .out_valid(out_valid), .layer5_result_read_signal(read_signal),
        .read_row_addr(read_row_addr), .read_col_addr(read_col_addr), .frame_done(frame_done)
    );

    layer5_result_ctrl #(.WIDTH(W), .COL_MAJOR_READ(1'b1)) dut_cm (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(cm_in_ready),
        .save_enable(cm_save_enable), .save_row_addr(cm_save_row_addr), .save_col_addr(cm_save_col_addr),
        .out_ready(out_ready), .out_valid(cm_out_valid), .layer5_result_read_signal(cm_read_signal),
        .read_row_addr(cm_read_row_addr), .read_col_addr(cm_read_col_addr), .frame_done(cm_frame_done)
    );

    layer5_result_ctrl #(.WIDTH(1), .COL_MAJOR_READ(1'b0)) dut_w1 (
        .clk(clk), .rst(rst), .flush(w1_flush), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .save_enable(w1_save_enable), .save_row_addr(w1_save_row_addr), .save_col_addr(w1_save_col_addr),
        .out_ready(w1_out_ready), .out_valid(w1_out_valid), .layer5_result_read_signal(w1_read_signal),
        .read_row_addr(w1_read_row_addr), .read_col_addr(w1_read_col_addr), .frame_done(w1_frame_done)
    );

    // Streams n writes; gap_mode 1 drops in_valid every third cycle; flush rides on handshake flush_at.
    task automatic fill_frame(input int n, input int gap_mode, input int flush_at);
        int idx = 0;
        int cyc = 0;
        int er, ec;
        for (int k = 0; k < n; k++) wq.push_back(k);
        while (wq.size() > 0 && cyc < 4 * n + 10) begin
            @(negedge clk);
            in_valid  = (gap_mode == 0) || (cyc % 3 != 1);
            flush     = (idx == flush_at) && in_valid;
            out_ready = 1'b1;
            #1;
            if (cyc == 0) fill_start_edge = edge_cnt;
            er = wq[0] / W;
            ec = wq[0] % W;
            checks++;
            if (save_row_addr !== 16'(er) || save_col_addr !== 16'(ec) || save_enable !== in_valid ||
                in_ready !== 1'b1 || out_valid !== 1'b0 || cm_save_row_addr !== 16'(er) ||
                cm_save_col_addr !== 16'(ec))
                $display("FAIL fill[%0d] got addr=(%0d,%0d) cm=(%0d,%0d) se=%b ir=%b ov=%b want addr=(%0d,%0d) se=%b ir=1 ov=0",
                         wq[0], save_row_addr, save_col_addr, cm_save_row_addr, cm_save_col_addr,
                         save_enable, in_ready, out_valid, er, ec, in_valid);
            else passes++;
            if (in_valid) begin
                void'(wq.pop_front());
                idx++;
            end
            cyc++;
        end
        if (wq.size() != 0) begin
            checks++;
            $display("FAIL fill_timeout got %0d writes left want 0", wq.size());
            wq.delete();
        end
    endtask

    // Drains n reads; stall_mode 1 drives out_ready 1,0,0,1 repeating.
    task automatic drain_frame(input int n, input int stall_mode, input bit flush_last,
                               input bit expect_done, input int done_cycle);
        int cyc = 0;
        int k, er, ec;
        bit pat;
        for (int i = 0; i < n; i++) rq.push_back(i);
        while (rq.size() > 0 && cyc < 4 * n + 10) begin
            @(negedge clk);
            pat       = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = 1'b0;
            out_ready = (stall_mode == 0) || pat;
            flush     = flush_last && (rq.size() == 1) && out_ready;
            #1;
            k  = rq[0];
            er = k / W;
            ec = k % W;
            checks++;
            if (out_valid !== 1'b1 || read_signal !== 1'b1 || in_ready !== 1'b0 || save_enable !== 1'b0 ||
                frame_done !== 1'b0 || read_row_addr !== 16'(er) || read_col_addr !== 16'(ec))
                $display("FAIL drain_rm[%0d] got ov=%b rs=%b ir=%b se=%b fd=%b addr=(%0d,%0d) want ov=1 rs=1 ir=0 se=0 fd=0 addr=(%0d,%0d)",
                         k, out_valid, read_signal, in_ready, save_enable, frame_done,
                         read_row_addr, read_col_addr, er, ec);
            else passes++;
            checks++;
            if (cm_out_valid !== 1'b1 || cm_read_row_addr !== 16'(ec) || cm_read_col_addr !== 16'(er))
                $display("FAIL drain_cm[%0d] got ov=%b addr=(%0d,%0d) want ov=1 addr=(%0d,%0d)",
                         k, cm_out_valid, cm_read_row_addr, cm_read_col_addr, ec, er);
            else passes++;
            if (out_ready) void'(rq.pop_front());
            cyc++;
        end
        if (rq.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout got %0d reads left want 0", rq.size());
            rq.delete();
        end
        if (expect_done) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
            #1;
            checks++;
            if (frame_done !== 1'b1 || cm_frame_done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL done_pulse got fd=%b cm_fd=%b ir=%b ov=%b want fd=1 cm_fd=1 ir=1 ov=0",
                         frame_done, cm_frame_done, in_ready, out_valid);
            else passes++;
            if (done_cycle > 0) begin
                checks++;
                if (int'(edge_cnt - fill_start_edge) + 1 != done_cycle)
                    $display("FAIL done_cycle got %0d want %0d", int'(edge_cnt - fill_start_edge) + 1, done_cycle);
                else passes++;
            end
            @(negedge clk);
            #1;
            checks++;
            if (frame_done !== 1'b0 || cm_frame_done !== 1'b0)
                $display("FAIL done_width got fd=%b cm_fd=%b want 0 0", frame_done, cm_frame_done);
            else passes++;
        end
        if (flush_last) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
            #1;
            checks++;
            if (frame_done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || read_row_addr !== 16'd0 ||
                read_col_addr !== 16'd0 || save_row_addr !== 16'd0 || save_col_addr !== 16'd0)
                $display("FAIL flush_last got fd=%b ir=%b ov=%b rd=(%0d,%0d) wr=(%0d,%0d) want fd=0 ir=1 ov=0 rd=(0,0) wr=(0,0)",
                         frame_done, in_ready, out_valid, read_row_addr, read_col_addr, save_row_addr, save_col_addr);
            else passes++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || read_signal !== 1'b0 || frame_done !== 1'b0 ||
            save_enable !== 1'b0 || save_row_addr !== 16'd0 || save_col_addr !== 16'd0 ||
            read_row_addr !== 16'd0 || read_col_addr !== 16'd0)
            $display("FAIL reset_vals got ir=%b ov=%b rs=%b fd=%b se=%b wr=(%0d,%0d) rd=(%0d,%0d) want 1 0 0 0 0 (0,0) (0,0)",
                     in_ready, out_valid, read_signal, frame_done, save_enable,
                     save_row_addr, save_col_addr, read_row_addr, read_col_addr);
        else passes++;
        in_valid = 1'b1;
        #1;
        checks++;
        if (save_enable !== 1'b1) $display("FAIL reset_se got %b want 1", save_enable);
        else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || cm_in_ready !== 1'b1 || w1_in_ready !== 1'b1)
            $display("FAIL reset_release got ir=%b ov=%b cm_ir=%b w1_ir=%b want 1 0 1 1",
                     in_ready, out_valid, cm_in_ready, w1_in_ready);
        else passes++;
    endtask

    task automatic test_row_major();
        fill_frame(W * W, 0, -1);
        drain_frame(W * W, 0, 1'b0, 1'b1, 2 * W * W + 1);
    endtask

    task automatic test_backpressure();
        fill_frame(W * W, 1, -1);
        drain_frame(W * W, 1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_flush_mid_fill();
        fill_frame(21, 0, 20);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (save_row_addr !== 16'd0 || save_col_addr !== 16'd0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL flush_fill got wr=(%0d,%0d) ir=%b ov=%b want (0,0) 1 0",
                     save_row_addr, save_col_addr, in_ready, out_valid);
        else passes++;
        fill_frame(W * W, 0, -1);
        drain_frame(W * W, 0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_flush_last();
        fill_frame(W * W, 0, -1);
        drain_frame(W * W, 0, 1'b1, 1'b0, 0);
        fill_frame(W * W, 0, -1);
        drain_frame(W * W, 0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_mid_reset();
        fill_frame(W * W, 0, -1);
        drain_frame(3 * W + 4, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || read_row_addr !== 16'd3 || read_col_addr !== 16'd4)
            $display("FAIL pre_reset got ov=%b rd=(%0d,%0d) want 1 (3,4)", out_valid, read_row_addr, read_col_addr);
        else passes++;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || read_signal !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0 ||
            read_row_addr !== 16'd0 || read_col_addr !== 16'd0 || cm_out_valid !== 1'b0)
            $display("FAIL async_reset got ov=%b rs=%b ir=%b fd=%b rd=(%0d,%0d) cm_ov=%b want 0 0 1 0 (0,0) 0",
                     out_valid, read_signal, in_ready, frame_done, read_row_addr, read_col_addr, cm_out_valid);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        fill_frame(W * W, 0, -1);
        drain_frame(W * W, 0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_width1();
        @(negedge clk);
        w1_in_valid = 1'b1; w1_out_ready = 1'b0;
        #1;
        checks++;
        if (w1_save_enable !== 1'b1 || w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0 ||
            w1_save_row_addr !== 16'd0 || w1_save_col_addr !== 16'd0)
            $display("FAIL w1_fill got se=%b ir=%b ov=%b wr=(%0d,%0d) want 1 1 0 (0,0)",
                     w1_save_enable, w1_in_ready, w1_out_valid, w1_save_row_addr, w1_save_col_addr);
        else passes++;
        @(negedge clk);
        w1_in_valid = 1'b0; w1_out_ready = 1'b1;
        #1;
        checks++;
        if (w1_out_valid !== 1'b1 || w1_in_ready !== 1'b0 || w1_frame_done !== 1'b0 ||
            w1_read_row_addr !== 16'd0 || w1_read_col_addr !== 16'd0)
            $display("FAIL w1_drain got ov=%b ir=%b fd=%b rd=(%0d,%0d) want 1 0 0 (0,0)",
                     w1_out_valid, w1_in_ready, w1_frame_done, w1_read_row_addr, w1_read_col_addr);
        else passes++;
        @(negedge clk);
        w1_out_ready = 1'b0;
        #1;
        checks++;
        if (w1_frame_done !== 1'b1 || w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0)
            $display("FAIL w1_done got fd=%b ir=%b ov=%b want 1 1 0", w1_frame_done, w1_in_ready, w1_out_valid);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_row_major();
        test_backpressure();
        test_flush_mid_fill();
        test_flush_last();
        test_mid_reset();
        test_width1();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/layer5_result_ctrl.md
# layer5_result_ctrl

Sequencer for the layer-5 result buffer: accepts one frame of layer-5 outputs from the convolution datapath over a valid/ready stream and drives the buffer's save_enable/save_row_addr/save_col_addr ports in raster order. Once the frame is full, it drains the buffer to the next stage (layer 6 / flatten) over a second valid/ready stream by driving layer5_result_read_signal and read_row_addr/read_col_addr. The buffer is single-ported per direction with no double buffering, so fill and drain are strictly serialized.

## Interface
- WIDTH, 8: buffer side length; a frame is WIDTH×WIDTH entries.
- COL_MAJOR_READ, 0: 0 = drain in row-major order; 1 = drain in column-major order (transposed flatten).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; discards the current frame and returns to FILL.
- in_valid  in  1  producer has a result word.
- in_ready  out  1  controller accepts a word (FILL only).
- save_enable  out  1  buffer write strobe = in_valid & in_ready.
- save_row_addr, save_col_addr  out  16 each  write address (zero-extended counters).
- out_ready  in  1  consumer accepts the current word.
- out_valid  out  1  buffer read data is valid (DRAIN only).
- layer5_result_read_signal  out  1  equals out_valid.
- read_row_addr, read_col_addr  out  16 each  read address.
- frame_done  out  1  one-cycle pulse after the last drain handshake.

## Operation
- State machine with states FILL and DRAIN. Reset state is FILL.
- **FILL**
  - in_ready=1; out_valid=0.
  - On in_valid: write at (wr_row, wr_col), then advance: col+1; at col=WIDTH-1, col←0 and row+1.
  - On the handshake at (WIDTH-1, WIDTH-1): counters wrap to 0 and the state goes to DRAIN.
- **DRAIN**
  - in_ready=0; save_enable=0; out_valid=1.
  - Address comes from the read counters.
  - Advance on out_valid & out_ready:
    - COL_MAJOR_READ=0: column is the inner index.
    - COL_MAJOR_READ=1: row is the inner index; read_row_addr=inner, read_col_addr=outer.
  - On the last handshake: counters go to 0, state goes to FILL, and frame_done is registered high for the next cycle.
- **flush**
  - flush=1 at an edge: state←FILL, all counters←0, frame_done←0.
  - Writes to the buffer are not undone.
  - flush overrides any handshake in the same cycle, including the last one. No frame_done is produced.
- Stalls:
  - in_valid=0 in FILL, or out_ready=0 in DRAIN: counters and addresses hold.
  - out_valid stays high with a stable address while stalled.
- Counter width is clog2(WIDTH), minimum 1. Addresses are zero-extended to 16 bits. WIDTH=1 is legal: each fill and each drain is one handshake.

## Timing
- Reset values (while rst=0 and immediately after):
  - state FILL, counters 0, in_ready=1, out_valid=0, layer5_result_read_signal=0, frame_done=0, all addresses 0.
  - save_enable follows in_valid.
- save_enable, addresses, in_ready and out_valid are combinational from registered state and counters plus in_valid. There are no registered outputs except frame_done.
- Write latency: data is in the buffer at the edge of the handshake.
- First drain word: out_valid rises the cycle after the final fill handshake. The buffer read is combinational, so data is valid in that same cycle.
- Throughput: one word per cycle in each phase.
- Minimum frame period is 2·WIDTH² cycles. frame_done coincides with the first FILL cycle of the next frame, and in_ready=1 in that cycle.
- rst asserted mid-frame: immediate return to reset values. Partial data in the buffer is ignored.

## Structure
- The shared CNN package holds typedef ctrl_state_e {FILL, DRAIN} and a localparam for address width (16).
- A natural sub-module is layer5_raster_cnt: a 2-D row/col counter with inputs en and clr, parameter WIDTH, and outputs inner/outer/last. It is instantiated twice, once for write and once for read.
- Top level: FSM, output muxing for COL_MAJOR_READ, and the frame_done register.
- Estimated 150–250 lines of RTL in total.

## Test plan
- **Reset:** with WIDTH=8, hold rst=0 with in_valid=0 → in_ready=1, out_valid=0, frame_done=0, all addresses 0. Release rst → still in FILL.
- **Full frame, row-major:** stream 64 words with in_valid always 1 → save addresses go (0,0),(0,1)…(0,7),(1,0)…(7,7). The next cycle gives out_valid=1 at (0,0). With out_ready=1, reads go row-major; frame_done pulses in cycle 129 and in_ready=1 in the same cycle.
- **Backpressure:** during DRAIN, toggle out_ready with pattern 1,0,0,1 → address holds at (0,1) across the stall, and out_valid never drops. Likewise, in_valid gaps in FILL hold the write address.
- **COL_MAJOR_READ=1:** after a full fill, drain order is (0,0),(1,0)…(7,0),(0,1)… → the last read is (7,7), then frame_done.
- **flush:** assert flush at write 20 → next cycle the address is (0,0) in FILL. Assert flush together with the last drain handshake → no frame_done, state is FILL, counters are 0.
- **Mid-frame reset:** assert rst during DRAIN at (3,4) → outputs take reset values asynchronously. After release, the first write goes to (0,0).
